// File: rtl/zvc_line_serializer.sv
// rtl/zvc_line_serializer.sv - serializes one compressed ZVC line (LIFM + mapping table) into OUT_LANES-wide beats
// Optional feature macro: ZVCS_EMPTY_BEAT_EN (an N=0 line emits one empty beat with out_last set)
module zvc_line_serializer #(
   parameter int WORD_WIDTH    = 8,
   parameter int DIST_WIDTH    = 7,
   parameter int MAX_LIFM_RSIZ = 4,
   parameter int CNT_WIDTH     = 8,
   parameter int OUT_LANES     = 16
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [128*WORD_WIDTH-1:0]                     lifm_comp,
   input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]       mt_comp,
   input  logic [CNT_WIDTH-1:0]                          nz_cnt,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [OUT_LANES*WORD_WIDTH-1:0]               out_lifm,
   output logic [OUT_LANES*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] out_mt,
   output logic [OUT_LANES-1:0]                          out_mask,
   output logic                                          out_last
);

   localparam int LINE   = 128;
   localparam int NBEATS = LINE / OUT_LANES;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int IW     = 8;
   localparam int MTW    = DIST_WIDTH * MAX_LIFM_RSIZ;
   localparam int LW     = LINE * WORD_WIDTH;
   localparam int MW     = LINE * MTW;

`ifdef ZVCS_EMPTY_BEAT_EN
   localparam bit EMPTY_BEAT = 1'b1;
`else
   localparam bit EMPTY_BEAT = 1'b0;
`endif

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                         state_q, state_d;
   logic [BW-1:0]                  beat_q, beat_d;
   logic [LW-1:0]                  lifm_q, lifm_d;
   logic [MW-1:0]                  mt_q, mt_d;
   logic [IW-1:0]                  cnt_q, cnt_d;
   logic                           out_valid_q, out_valid_d;
   logic                           out_last_q, out_last_d;
   logic [OUT_LANES-1:0]           out_mask_q, out_mask_d;
   logic [OUT_LANES*WORD_WIDTH-1:0] out_lifm_q, out_lifm_d;
   logic [OUT_LANES*MTW-1:0]       out_mt_q, out_mt_d;

   logic                           accept;
   logic                           handshake;
   logic [IW-1:0]                  cnt_in;
   logic [LW-1:0]                  sel_lifm;
   logic [MW-1:0]                  sel_mt;
   logic [IW-1:0]                  sel_cnt;
   logic [BW-1:0]                  k_sel;
   logic [IW-1:0]                  base;
   logic [OUT_LANES*WORD_WIDTH-1:0] beat_lifm;
   logic [OUT_LANES*MTW-1:0]       beat_mt;
   logic [OUT_LANES-1:0]           beat_mask;
   logic                           beat_last;

   // A new line can be taken while idle or in the same cycle the last beat leaves
   assign in_ready  = (state_q == IDLE) || (out_ready && out_last_q);
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid_q && out_ready;
   assign cnt_in    = (nz_cnt > CNT_WIDTH'(LINE)) ? IW'(LINE) : IW'(nz_cnt);

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_mask  = out_mask_q;
   assign out_lifm  = out_lifm_q;
   assign out_mt    = out_mt_q;

   // Beat builder: beat 0 of the incoming line on accept, else the next beat of the buffered line
   always_comb begin
      sel_lifm  = accept ? lifm_comp : lifm_q;
      sel_mt    = accept ? mt_comp : mt_q;
      sel_cnt   = accept ? cnt_in : cnt_q;
      k_sel     = accept ? '0 : beat_q + BW'(1);
      base      = IW'(k_sel) * IW'(OUT_LANES);
      beat_lifm = '0;
      beat_mt   = '0;
      beat_mask = '0;
      for (int i = 0; i < OUT_LANES; i++) begin
         if ((base + IW'(i)) < sel_cnt) begin
            beat_mask[i] = 1'b1;
            beat_lifm[i*WORD_WIDTH +: WORD_WIDTH] = sel_lifm[(int'(base) + i)*WORD_WIDTH +: WORD_WIDTH];
            beat_mt[i*MTW +: MTW] = sel_mt[(int'(base) + i)*MTW +: MTW];
         end
      end
      beat_last = ({1'b0, base} + (IW+1)'(OUT_LANES)) >= {1'b0, sel_cnt};
   end

   // Next-state: capture on accept, advance only on handshake, clear outputs after the last beat
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      lifm_d      = lifm_q;
      mt_d        = mt_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_mask_d  = out_mask_q;
      out_lifm_d  = out_lifm_q;
      out_mt_d    = out_mt_q;
      if (accept) begin
         lifm_d = lifm_comp;
         mt_d   = mt_comp;
         cnt_d  = cnt_in;
         beat_d = '0;
         if ((cnt_in != '0) || EMPTY_BEAT) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_last_d  = beat_last;
            out_mask_d  = beat_mask;
            out_lifm_d  = beat_lifm;
            out_mt_d    = beat_mt;
         end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_mask_d  = '0;
            out_lifm_d  = '0;
            out_mt_d    = '0;
         end
      end else if (handshake) begin
         if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_mask_d  = '0;
            out_lifm_d  = '0;
            out_mt_d    = '0;
         end else begin
            beat_d      = k_sel;
            out_last_d  = beat_last;
            out_mask_d  = beat_mask;
            out_lifm_d  = beat_lifm;
            out_mt_d    = beat_mt;
         end
      end
   end

   // State, line buffer and registered outputs; reset discards any line in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         lifm_q      <= '0;
         mt_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_mask_q  <= '0;
         out_lifm_q  <= '0;
         out_mt_q    <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         lifm_q      <= lifm_d;
         mt_q        <= mt_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_mask_q  <= out_mask_d;
         out_lifm_q  <= out_lifm_d;
         out_mt_q    <= out_mt_d;
      end
   end

endmodule

// File: tb/tb_zvc_line_serializer.sv
// tb/tb_zvc_line_serializer.sv - self-checking bench for zvc_line_serializer
module tb_zvc_line_serializer;

   localparam int WW  = 8;
   localparam int DW  = 7;
   localparam int RS  = 4;
   localparam int CW  = 8;
   localparam int NL  = 16;
   localparam int MTW = DW * RS;
   localparam int LW  = 128 * WW;
   localparam int MW  = 128 * MTW;
   localparam int OLW = NL * WW;
   localparam int OMW = NL * MTW;
`ifdef ZVCS_EMPTY_BEAT_EN
   localparam int EB0 = 1;
`else
   localparam int EB0 = 0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [LW-1:0]  lifm_comp;
   logic [MW-1:0]  mt_comp;
   logic [CW-1:0]  nz_cnt;
   logic           out_valid;
   logic           out_ready;
   logic [OLW-1:0] out_lifm;
   logic [OMW-1:0] out_mt;
   logic [NL-1:0]  out_mask;
   logic           out_last;

   int total = 0;
   int bad   = 0;

   zvc_line_serializer #(
      .WORD_WIDTH(WW), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(RS), .CNT_WIDTH(CW), .OUT_LANES(NL)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .lifm_comp(lifm_comp), .mt_comp(mt_comp), .nz_cnt(nz_cnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm),
      .out_mt(out_mt), .out_mask(out_mask), .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   typedef struct {
      int            n;
      int            stall_beat;
      int            stall_cyc;
      int            exp_beats;
      logic [NL-1:0] exp_last_mask;
   } vec_t;

   task automatic chk(input string name, input logic [447:0] got, input logic [447:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic int exp_beats_of(input int n);
      int nc;
      nc = (n > 128) ? 128 : n;
      return (nc == 0) ? EB0 : (nc + NL - 1) / NL;
   endfunction

   // Reference: beat k holds entries k*NL.. of the line, entries at or past N are zero
   task automatic model_beat(input logic [LW-1:0] l, input logic [MW-1:0] m, input int n, input int k,
                             output logic [OLW-1:0] el, output logic [OMW-1:0] em,
                             output logic [NL-1:0] emask, output logic elast);
      int nc;
      int e;
      nc    = (n > 128) ? 128 : n;
      el    = '0;
      em    = '0;
      emask = '0;
      for (int i = 0; i < NL; i++) begin
         e = k * NL + i;
         if (e < nc) begin
            emask[i] = 1'b1;
            el[i*WW +: WW] = l[e*WW +: WW];
            em[i*MTW +: MTW] = m[e*MTW +: MTW];
         end
      end
      elast = ((k + 1) * NL >= nc);
   endtask

   task automatic check_beat(input logic [LW-1:0] l, input logic [MW-1:0] m, input int n, input int k);
      logic [OLW-1:0] el;
      logic [OMW-1:0] em;
      logic [NL-1:0]  emask;
      logic           elast;
      model_beat(l, m, n, k, el, em, emask, elast);
      chk($sformatf("valid n=%0d k=%0d", n, k), out_valid, 1'b1);
      chk($sformatf("mask n=%0d k=%0d", n, k), out_mask, emask);
      chk($sformatf("lifm n=%0d k=%0d", n, k), out_lifm, el);
      chk($sformatf("mt n=%0d k=%0d", n, k), out_mt, em);
      chk($sformatf("last n=%0d k=%0d", n, k), out_last, elast);
   endtask

   task automatic rand_line(output logic [LW-1:0] l, output logic [MW-1:0] m);
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
   endtask

   // Offers one line, then follows its beats until the last one leaves (bounded)
   task automatic run_line(input int n, input bit rnd_ready, input int stall_beat, input int stall_cyc,
                           output int beats, output logic [NL-1:0] lastmask);
      logic [LW-1:0]  l, gl;
      logic [MW-1:0]  m, gm;
      logic [OLW-1:0] p_lifm;
      logic [OMW-1:0] p_mt;
      logic [NL-1:0]  p_mask;
      logic           p_last;
      bit             was_stalled;
      bit             done;
      int             k, stalled, eb;
      rand_line(l, m);
      eb = exp_beats_of(n);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1'b1);
      lifm_comp = l;
      mt_comp   = m;
      nz_cnt    = CW'(n);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      rand_line(gl, gm);
      lifm_comp = gl;
      mt_comp   = gm;
      nz_cnt    = CW'($urandom);
      chk($sformatf("latency n=%0d", n), out_valid, (eb > 0));
      k = 0; stalled = 0; done = 0; was_stalled = 0; lastmask = '0;
      p_lifm = '0; p_mt = '0; p_mask = '0; p_last = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (out_valid) begin
            if (was_stalled) begin
               chk("hold_lifm", out_lifm, p_lifm);
               chk("hold_mt", out_mt, p_mt);
               chk("hold_mask", out_mask, p_mask);
               chk("hold_last", out_last, p_last);
            end
            if (k >= eb) begin
               chk($sformatf("extra_beat n=%0d", n), 1'b1, 1'b0);
               done = 1;
            end else begin
               check_beat(l, m, n, k);
               if (stall_beat == k && stalled < stall_cyc) begin
                  out_ready = 1'b0;
                  stalled++;
               end else begin
                  out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
               end
               was_stalled = !out_ready;
               p_lifm = out_lifm; p_mt = out_mt; p_mask = out_mask; p_last = out_last;
               if (out_ready) begin
                  if (out_last) begin
                     done = 1;
                     lastmask = out_mask;
                  end
                  k++;
               end
            end
         end
         @(negedge clk);
      end
      if (!done && eb > 0) chk($sformatf("timeout n=%0d", n), 1'b1, 1'b0);
      out_ready = 1'b1;
      beats = k;
   endtask

   initial begin
      vec_t          vecs[9];
      int            beats;
      logic [NL-1:0] lm;
      logic [LW-1:0] la, lb;
      logic [MW-1:0] ma, mb;
      int            vcnt;

      vecs[0] = '{n: 40,  stall_beat: -1, stall_cyc: 0, exp_beats: 3,   exp_last_mask: 16'h00FF};
      vecs[1] = '{n: 20,  stall_beat: 0,  stall_cyc: 5, exp_beats: 2,   exp_last_mask: 16'h000F};
      vecs[2] = '{n: 128, stall_beat: -1, stall_cyc: 0, exp_beats: 8,   exp_last_mask: 16'hFFFF};
      vecs[3] = '{n: 200, stall_beat: -1, stall_cyc: 0, exp_beats: 8,   exp_last_mask: 16'hFFFF};
      vecs[4] = '{n: 16,  stall_beat: -1, stall_cyc: 0, exp_beats: 1,   exp_last_mask: 16'hFFFF};
      vecs[5] = '{n: 17,  stall_beat: 1,  stall_cyc: 2, exp_beats: 2,   exp_last_mask: 16'h0001};
      vecs[6] = '{n: 1,   stall_beat: -1, stall_cyc: 0, exp_beats: 1,   exp_last_mask: 16'h0001};
      vecs[7] = '{n: 0,   stall_beat: -1, stall_cyc: 0, exp_beats: EB0, exp_last_mask: 16'h0000};
      vecs[8] = '{n: 127, stall_beat: 3,  stall_cyc: 1, exp_beats: 8,   exp_last_mask: 16'h7FFF};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      lifm_comp = '0; mt_comp = '0; nz_cnt = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_mask", out_mask, '0);
      chk("rst_out_lifm", out_lifm, '0);
      chk("rst_out_mt", out_mt, '0);
      chk("rst_in_ready", in_ready, 1'b1);

      for (int v = 0; v < 9; v++) begin
         run_line(vecs[v].n, 1'b0, vecs[v].stall_beat, vecs[v].stall_cyc, beats, lm);
         chk($sformatf("vec%0d_beats", v), beats, vecs[v].exp_beats);
         chk($sformatf("vec%0d_last_mask", v), lm, vecs[v].exp_last_mask);
         if (vecs[v].n == 0) chk("n0_in_ready", in_ready, 1'b1);
      end

      // Back-to-back: N=128 then N=16 held on the input, no bubble between lines
      rand_line(la, ma);
      rand_line(lb, mb);
      @(negedge clk);
      lifm_comp = la; mt_comp = ma; nz_cnt = 8'd128; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      lifm_comp = lb; mt_comp = mb; nz_cnt = 8'd16;
      for (int k = 0; k < 8; k++) begin
         check_beat(la, ma, 128, k);
         chk($sformatf("b2b_in_ready k=%0d", k), in_ready, (k == 7));
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_beat(lb, mb, 16, 0);
      @(negedge clk);
      chk("b2b_idle_after", out_valid, 1'b0);

      // Reset during beat 1 of an N=64 line
      rand_line(la, ma);
      @(negedge clk);
      lifm_comp = la; mt_comp = ma; nz_cnt = 8'd64; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_beat(la, ma, 64, 0);
      @(negedge clk);
      check_beat(la, ma, 64, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_out_last", out_last, 1'b0);
      chk("mrst_out_mask", out_mask, '0);
      chk("mrst_out_lifm", out_lifm, '0);
      chk("mrst_out_mt", out_mt, '0);
      chk("mrst_in_ready", in_ready, 1'b1);
      vcnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      chk("mrst_no_more_beats", vcnt, 0);

      // Randomized lines with random backpressure
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(0, 255);
         run_line(n, 1'b1, -1, 0, beats, lm);
         chk($sformatf("rnd%0d_beats n=%0d", r, n), beats, exp_beats_of(n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
